// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - column partial-sum window accumulator with round/shift/relu/saturate output stage
module psum_accumulator #(
    parameter int OUT_WIDTH        = 16,
    parameter int COLUMN_OUT_WIDTH = OUT_WIDTH + 3,
    parameter int ACC_WIDTH        = COLUMN_OUT_WIDTH + 3,
    parameter int PIX_WIDTH        = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [1:0]                  i_mode,
    input  logic [COLUMN_OUT_WIDTH-1:0] i_psum_column,
    input  logic                        i_psum_valid,
    output logic                        o_psum_ready,
    input  logic [3:0]                  i_shift,
    input  logic                        i_relu_en,
    output logic [PIX_WIDTH-1:0]        o_pixel,
    output logic                        o_pixel_valid,
    input  logic                        i_pixel_ready,
    output logic                        o_busy
);

    // One guard bit above the accumulator so the rounding add can never wrap.
    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] PIX_MAX = {{(EW-PIX_WIDTH+1){1'b0}}, {(PIX_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] PIX_MIN = {{(EW-PIX_WIDTH+1){1'b1}}, {(PIX_WIDTH-1){1'b0}}};

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic [1:0]                  mode_q, mode_d;
    logic [3:0]                  shift_q, shift_d;
    logic                        relu_q, relu_d;
    logic [PIX_WIDTH-1:0]        pixel_q, pixel_d;

    logic                        accept;
    logic [1:0]                  eff_mode;
    logic [3:0]                  eff_shift;
    logic                        eff_relu;
    logic [2:0]                  win_len;
    logic signed [ACC_WIDTH-1:0] beat_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [EW-1:0]        sum_ext;
    logic signed [EW-1:0]        round_c;
    logic signed [EW-1:0]        rounded;
    logic signed [EW-1:0]        shifted;
    logic signed [EW-1:0]        clamped;

    always_comb begin
        accept    = i_psum_valid && (state_q == ST_ACC);
        // The first beat of a window uses live config; later beats use the latched copy.
        eff_mode  = (cnt_q == 3'd0) ? i_mode    : mode_q;
        eff_shift = (cnt_q == 3'd0) ? i_shift   : shift_q;
        eff_relu  = (cnt_q == 3'd0) ? i_relu_en : relu_q;
        win_len   = {1'b0, eff_mode} + 3'd3;

        beat_ext = {{(ACC_WIDTH-COLUMN_OUT_WIDTH){i_psum_column[COLUMN_OUT_WIDTH-1]}}, i_psum_column};
        sum      = acc_q + beat_ext;
        sum_ext  = {sum[ACC_WIDTH-1], sum};
        round_c  = (eff_shift == 4'd0) ? '0 : (EW'(1) << (eff_shift - 4'd1));
        rounded  = sum_ext + round_c;
        shifted  = rounded >>> eff_shift;

        clamped = shifted;
        if (eff_relu && shifted < 0) begin
            clamped = '0;
        end else if (shifted > PIX_MAX) begin
            clamped = PIX_MAX;
        end else if (shifted < PIX_MIN) begin
            clamped = PIX_MIN;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        pixel_d = pixel_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    mode_d  = eff_mode;
                    shift_d = eff_shift;
                    relu_d  = eff_relu;
                    acc_d   = sum;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q + 3'd1 == win_len) begin
                        state_d = ST_OUT;
                        pixel_d = clamped[PIX_WIDTH-1:0];
                    end
                end
            end
            ST_OUT: begin
                if (i_pixel_ready) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            pixel_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            pixel_q <= pixel_d;
        end
    end

    // All outputs come from registers only.
    assign o_psum_ready  = (state_q == ST_ACC);
    assign o_pixel_valid = (state_q == ST_OUT);
    assign o_pixel       = pixel_q;
    assign o_busy        = (cnt_q != 3'd0) || (state_q == ST_OUT);

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - self-checking bench for psum_accumulator
module tb_psum_accumulator;

    localparam int CW = 19;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic [CW-1:0] psum_col;
    logic          psum_valid;
    logic          psum_ready;
    logic [3:0]    shift;
    logic          relu;
    logic [PW-1:0] pixel;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int npix  = 0;

    always #5 clk = ~clk;

    psum_accumulator dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_mode        (mode),
        .i_psum_column (psum_col),
        .i_psum_valid  (psum_valid),
        .o_psum_ready  (psum_ready),
        .i_shift       (shift),
        .i_relu_en     (relu),
        .o_pixel       (pixel),
        .o_pixel_valid (pixel_valid),
        .i_pixel_ready (pixel_ready),
        .o_busy        (busy)
    );

    always @(negedge clk) begin
        if (rst_n && pixel_valid && pixel_ready) npix++;
    end

    function automatic logic [PW-1:0] model(input longint s, input int sh, input bit rl);
        longint v;
        v = s;
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (rl && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return PW'(v);
    endfunction

    task automatic send(input int v);
        int t;
        t = 0;
        psum_valid = 1'b1;
        psum_col   = CW'(v);
        do begin
            @(negedge clk);
            t++;
        end while (!psum_ready && t < 50);
        @(posedge clk);
        #1;
        psum_valid = 1'b0;
        if (t >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout: ready=%0b required=1", psum_ready);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mode = 2'd0; shift = 4'd0; relu = 1'b0;
        psum_valid = 1'b0; psum_col = '0; pixel_ready = 1'b1;
        idle(3);
        rst_n = 1'b1;
        total++;
        if (pixel !== 8'd0 || pixel_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: pixel=%0d valid=%0b busy=%0b required 0/0/0", pixel, pixel_valid, busy);
        end
        idle(1);
        total++;
        if (psum_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got=%0b required=1", psum_ready);
        end
    endtask

    task automatic test_back_to_back;
        int p0;
        p0 = npix;
        mode = 2'd1; shift = 4'd0; relu = 1'b0; pixel_ready = 1'b1;
        send(10); send(20); send(30);
        total++;
        if (busy !== 1'b1 || pixel_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_midwindow: busy=%0b valid=%0b required 1/0", busy, pixel_valid);
        end
        send(40);
        total++;
        if (pixel_valid !== 1'b1 || pixel !== 8'd100 || psum_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_result: valid=%0b pixel=%0d ready=%0b required 1/100/0", pixel_valid, $signed(pixel), psum_ready);
        end
        idle(1);
        total++;
        if (pixel_valid !== 1'b0 || psum_ready !== 1'b1 || busy !== 1'b0 || npix - p0 != 1) begin
            bad++;
            $display("FAIL b2b_pulse: valid=%0b ready=%0b busy=%0b pulses=%0d required 0/1/0/1", pixel_valid, psum_ready, busy, npix - p0);
        end
    endtask

    task automatic test_saturate_relu;
        for (int r = 0; r < 2; r++) begin
            mode = 2'd0; shift = 4'd0; relu = r[0];
            send(-50); send(-50); send(-50);
            total++;
            if (pixel_valid !== 1'b1 || pixel !== (r == 0 ? 8'h80 : 8'h00)) begin
                bad++;
                $display("FAIL sat_relu%0d: valid=%0b pixel=%0d required 1/%0d", r, pixel_valid, $signed(pixel), r == 0 ? -128 : 0);
            end
            idle(1);
        end
    endtask

    task automatic test_shift_round;
        mode = 2'd0; shift = 4'd2; relu = 1'b0;
        send(3); send(3); send(4);
        total++;
        if (pixel_valid !== 1'b1 || pixel !== 8'd3) begin
            bad++;
            $display("FAIL shift_round: valid=%0b pixel=%0d required 1/3", pixel_valid, $signed(pixel));
        end
        idle(1);
        shift = 4'd0;
        send(1000); send(1000); send(1000);
        total++;
        if (pixel_valid !== 1'b1 || pixel !== 8'd127) begin
            bad++;
            $display("FAIL sat_pos: valid=%0b pixel=%0d required 1/127", pixel_valid, $signed(pixel));
        end
        idle(1);
    endtask

    task automatic test_stall_mode;
        mode = 2'd3; shift = 4'd0; relu = 1'b0; pixel_ready = 1'b1;
        send(1); idle(2); send(1);
        mode = 2'd1;
        idle(1); send(1); idle(3); send(1); send(1);
        pixel_ready = 1'b0;
        idle(2);
        send(1);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (pixel_valid !== 1'b1 || pixel !== 8'd6 || psum_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d: valid=%0b pixel=%0d ready=%0b required 1/6/0", c, pixel_valid, $signed(pixel), psum_ready);
            end
            idle(1);
        end
        pixel_ready = 1'b1;
        idle(1);
        total++;
        if (pixel_valid !== 1'b0 || psum_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: valid=%0b ready=%0b required 0/1", pixel_valid, psum_ready);
        end
        send(2); send(2); send(2); send(2);
        total++;
        if (pixel_valid !== 1'b1 || pixel !== 8'd8) begin
            bad++;
            $display("FAIL next_mode01: valid=%0b pixel=%0d required 1/8", pixel_valid, $signed(pixel));
        end
        idle(1);
    endtask

    task automatic test_reset_mid;
        int p0;
        p0 = npix;
        mode = 2'd2; shift = 4'd0; relu = 1'b0;
        send(7); send(7); send(7);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        total++;
        if (busy !== 1'b0 || pixel_valid !== 1'b0 || pixel !== 8'd0) begin
            bad++;
            $display("FAIL rst_mid: busy=%0b valid=%0b pixel=%0d required 0/0/0", busy, pixel_valid, pixel);
        end
        for (int k = 0; k < 5; k++) send(2);
        total++;
        if (pixel_valid !== 1'b1 || pixel !== 8'd10) begin
            bad++;
            $display("FAIL rst_mid_after: valid=%0b pixel=%0d required 1/10", pixel_valid, $signed(pixel));
        end
        idle(1);
        total++;
        if (npix - p0 != 1) begin
            bad++;
            $display("FAIL rst_mid_count: pixels=%0d required 1", npix - p0);
        end
        pixel_ready = 1'b0;
        send(5); send(5); send(5); send(5); send(5);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        pixel_ready = 1'b1;
        total++;
        if (pixel_valid !== 1'b0 || busy !== 1'b0 || psum_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_out: valid=%0b busy=%0b ready=%0b required 0/0/1", pixel_valid, busy, psum_ready);
        end
    endtask

    task automatic test_random;
        int      m, sh, n, v;
        bit      rl;
        longint  s;
        logic [PW-1:0] exp_px;
        for (int w = 0; w < 40; w++) begin
            m  = $urandom_range(0, 3);
            sh = $urandom_range(0, 15);
            rl = 1'($urandom_range(0, 1));
            n  = m + 3;
            s  = 0;
            mode = 2'(m); shift = 4'(sh); relu = rl;
            pixel_ready = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (($urandom & 3) == 0) v = $urandom_range(0, 600) - 300;
                else v = int'($urandom_range(0, 524287)) - 262144;
                s += v;
                idle($urandom_range(0, 2));
                send(v);
                mode  = 2'($urandom_range(0, 3));
                shift = 4'($urandom_range(0, 15));
                relu  = 1'($urandom_range(0, 1));
            end
            exp_px = model(s, sh, rl);
            idle($urandom_range(0, 3));
            total++;
            if (pixel_valid !== 1'b1 || pixel !== exp_px) begin
                bad++;
                $display("FAIL rand_w%0d: valid=%0b pixel=%0d required 1/%0d (mode=%0d shift=%0d relu=%0b sum=%0d)",
                         w, pixel_valid, $signed(pixel), $signed(exp_px), m, sh, rl, s);
            end
            pixel_ready = 1'b1;
            idle(1);
        end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_saturate_relu;
        test_shift_round;
        test_stall_mode;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
